pll_50_to_25: RTL and testbench

// - Clock generator: derives the 25 MHz VGA pixel clock c0 from the 50 MHz board clock inclk0.
// - Provides a lock indicator that downstream logic ANDs into its reset, holding the video core
//   in reset until c0 is declared stable.
// - Synthesizable register-based divider; drop-in for a vendor PLL with the same port names.

---
 rtl/pll_50_to_25.sv | 69 ++++++
 tb/tb_pll_50_to_25.sv | 106 ++++++++++
 2 files changed

// File: rtl/pll_50_to_25.sv
// Register-based clock divider with lock indicator; drop-in replacement for a vendor PLL
// producing the 25 MHz pixel clock c0 from the 50 MHz reference inclk0.
module pll_50_to_25 #(
  parameter int DIV         = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int CNT_W       = 16
) (
  input  logic inclk0,
  input  logic areset,
  output logic c0,
  output logic locked
);

  localparam int PH_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PH_W-1:0]  PH_MAX   = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(DIV / 2);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

  if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
    $fatal(1, "pll_50_to_25: DIV must be even and >= 2");
  end
  if ((LOCK_CYCLES < 1) || (LOCK_CYCLES >= (1 << CNT_W))) begin : g_bad_lock
    $fatal(1, "pll_50_to_25: LOCK_CYCLES must be >= 1 and < 2**CNT_W");
  end

  logic rst_meta;
  logic rst_sync;

  // Release is resynchronised so the divider never starts on a metastable reset edge;
  // assertion still propagates asynchronously through the set path.
  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking here is what makes these two flops a shift chain, not one wire.
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
    end
  end

  logic [PH_W-1:0]  ph;
  logic [PH_W-1:0]  ph_next;
  logic [CNT_W-1:0] lc;
  logic [CNT_W-1:0] lc_next;

  always_comb begin
    // NOTE: every output of this block is assigned before any branch, so no latch is inferred.
    ph_next = (ph == PH_MAX) ? '0 : ph + 1'b1;
    lc_next = (lc < LOCK_MAX) ? lc + 1'b1 : lc;
    // lc is zero only on the first edge after release; that edge loads phase 0 so c0 rises.
    if (lc == '0) ph_next = '0;
  end

  always_ff @(posedge inclk0 or posedge rst_sync) begin
    if (rst_sync) begin
      ph     <= '0;
      lc     <= '0;
      c0     <= 1'b0;
      locked <= 1'b0;
    end else begin
      ph     <= ph_next;
      lc     <= lc_next;
      c0     <= (ph_next < PH_HALF);
      locked <= (lc_next == LOCK_MAX);
    end
  end

endmodule

// File: tb/tb_pll_50_to_25.sv
// Randomised reset-sequence bench for pll_50_to_25 in its default (DIV=2) and a DIV=4
// configuration, checked every cycle against an edge-count model.
module tb_pll_50_to_25;

  localparam int DIV_A  = 2;
  localparam int LOCK_A = 1024;
  localparam int DIV_B  = 4;
  localparam int LOCK_B = 8;
  localparam int SYNC   = 2;

  logic clk    = 1'b0;
  logic areset = 1'b1;
  logic c0_a, locked_a, c0_b, locked_b;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;  // rising edges seen since areset last fell

  pll_50_to_25 #(.DIV(DIV_A), .LOCK_CYCLES(LOCK_A), .CNT_W(16)) u_dut_a (
    .inclk0(clk), .areset(areset), .c0(c0_a), .locked(locked_a)
  );

  pll_50_to_25 #(.DIV(DIV_B), .LOCK_CYCLES(LOCK_B), .CNT_W(4)) u_dut_b (
    .inclk0(clk), .areset(areset), .c0(c0_b), .locked(locked_b)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // c0 rises on edge SYNC+1 and then repeats DIV/2 high, DIV/2 low.
  function automatic logic exp_c0(input int edges, input int div);
    if (edges <= SYNC) return 1'b0;
    return ((edges - SYNC - 1) % div) < (div / 2);
  endfunction

  function automatic logic exp_locked(input int edges, input int lock);
    return edges >= (lock + SYNC);
  endfunction

  always @(posedge clk or posedge areset) begin
    if (areset) k <= 0;
    else        k <= k + 1;
  end

  always @(negedge clk) begin
    check("c0_a",     {31'd0, c0_a},     {31'd0, exp_c0(k, DIV_A)});
    check("locked_a", {31'd0, locked_a}, {31'd0, exp_locked(k, LOCK_A)});
    check("c0_b",     {31'd0, c0_b},     {31'd0, exp_c0(k, DIV_B)});
    check("locked_b", {31'd0, locked_b}, {31'd0, exp_locked(k, LOCK_B)});
  end

  task automatic check_all_low(input string tag);
    check({tag, "_c0_a"},     {31'd0, c0_a},     32'd0);
    check({tag, "_locked_a"}, {31'd0, locked_a}, 32'd0);
    check({tag, "_c0_b"},     {31'd0, c0_b},     32'd0);
    check({tag, "_locked_b"}, {31'd0, locked_b}, 32'd0);
  endtask

  initial begin
    logic found;

    // Reset held with the clock running; the per-cycle checks see all outputs low.
    repeat (20) @(posedge clk);
    #5 areset = 1'b0;

    // Full lock of the default instance plus a long stable stretch.
    repeat (LOCK_A + SYNC + 5000) @(posedge clk);

    // Asynchronous reset while c0 and locked are both high.
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(posedge clk);
      #3 found = c0_a;
    end
    check("pre_reset_c0_a",     {31'd0, c0_a},     32'd1);
    check("pre_reset_locked_a", {31'd0, locked_a}, 32'd1);
    areset = 1'b1;
    #1 check_all_low("async_assert");
    repeat (3) @(posedge clk);
    #4 areset = 1'b0;
    repeat (LOCK_A + SYNC + 4) @(posedge clk);
    #1 check("relock_a", {31'd0, locked_a}, 32'd1);

    // Random run lengths and mid-cycle reset pulses at random offsets.
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(1500, 3)) @(posedge clk);
      #($urandom_range(8, 1)) areset = 1'b1;
      #1 check_all_low("rand_assert");
      repeat ($urandom_range(5, 1)) @(posedge clk);
      #($urandom_range(8, 1)) areset = 1'b0;
    end

    repeat (50) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
